memory_port_arbiter: RTL and testbench

- Shares one memory port between the instruction-fetch requester and the load/store requester.
- Round-robin arbitration on requests. A tag FIFO records the owner of each outstanding read.
- Returned read data (from memory_data_in, the same bus that feeds memory_receive) is steered back to the requester that issued the read.
- Sits between the core's fetch/memory stages and the shared memory interface, beside memory_receive.

---
 rtl/memory_arbiter_pkg.sv | 17 +
 rtl/memory_port_arbiter_owner_tag_fifo.sv | 70 +++++++
 rtl/memory_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_memory_port_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared constants for the memory port arbiter: owner tag encoding and a
// width helper used to size FIFO pointers.
package memory_arbiter_pkg;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/memory_port_arbiter_owner_tag_fifo.sv
// Owner tag FIFO: one bit per outstanding read, recording which requester
// issued it. Full/empty are registered; a pop never frees space for a same-cycle push.
module owner_tag_fifo
  import memory_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             push_tag,
  input  logic             pop,
  output logic             pop_tag,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] tags_q, tags_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      tags_d[wr_ptr_q] = push_tag;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      tags_q   <= tags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign pop_tag = tags_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store,
// steering in-order read responses back by owner tag. Optional stall counters
// are enabled with MEMORY_ARBITER_PERF_EN.
module memory_port_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int OUTSTANDING  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fetch_read,
  input  logic [ADDRESS_BITS-1:0] fetch_address,
  output logic                    fetch_grant,
  output logic                    fetch_valid,
  output logic [DATA_WIDTH-1:0]   fetch_data,
  input  logic                    data_read,
  input  logic                    data_write,
  input  logic [ADDRESS_BITS-1:0] data_address,
  input  logic [DATA_WIDTH-1:0]   data_write_data,
  output logic                    data_grant,
  output logic                    data_valid,
  output logic [DATA_WIDTH-1:0]   data_load_data,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  input  logic                    mem_ready,
  input  logic                    memory_valid,
  input  logic [DATA_WIDTH-1:0]   memory_data_in,
  output logic                    response_error,
`ifdef MEMORY_ARBITER_PERF_EN
  output logic [31:0]             fetch_stall_count,
  output logic [31:0]             data_stall_count,
`endif
  input  logic                    scan
);

  localparam int CNT_W = clog2(OUTSTANDING) + 1;

  logic             last_grant_q, last_grant_d;
  logic             response_error_q, response_error_d;
  logic             fetch_elig, wr_elig, rd_elig, data_elig;
  logic             fetch_win, data_win;
  logic             fifo_push, fifo_push_tag, fifo_pop, fifo_pop_tag;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Handshake: a requester's *_grant is high in the cycle its request is
  // accepted; until then it holds request, address and data stable.
  always_comb begin
    fetch_elig = fetch_read && !fifo_full;
    wr_elig    = data_write;
    rd_elig    = data_read && !data_write && !fifo_full;
    data_elig  = wr_elig || rd_elig;
    fetch_win  = 1'b0;
    data_win   = 1'b0;
    if (mem_ready) begin
      if (fetch_elig && data_elig) begin
        fetch_win = (last_grant_q == OWNER_DATA);
        data_win  = (last_grant_q == OWNER_FETCH);
      end else begin
        fetch_win = fetch_elig;
        data_win  = data_elig;
      end
    end

    last_grant_d = last_grant_q;
    if (fetch_win)     last_grant_d = OWNER_FETCH;
    else if (data_win) last_grant_d = OWNER_DATA;

    fetch_grant    = fetch_win;
    data_grant     = data_win;
    mem_read       = fetch_win || (data_win && rd_elig);
    mem_write      = data_win && wr_elig;
    mem_address    = '0;
    mem_write_data = '0;
    if (fetch_win)     mem_address = fetch_address;
    else if (data_win) mem_address = data_address;
    if (mem_write) mem_write_data = data_write_data;

    fifo_push     = mem_read;
    fifo_push_tag = data_win ? OWNER_DATA : OWNER_FETCH;

    // Responses are in order, so the FIFO head always names the owner.
    fifo_pop       = memory_valid && !fifo_empty;
    fetch_valid    = fifo_pop && (fifo_pop_tag == OWNER_FETCH);
    data_valid     = fifo_pop && (fifo_pop_tag == OWNER_DATA);
    fetch_data     = fetch_valid ? memory_data_in : '0;
    data_load_data = data_valid ? memory_data_in : '0;

    response_error_d = response_error_q || (memory_valid && fifo_empty);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q     <= OWNER_DATA;
      response_error_q <= 1'b0;
    end else begin
      last_grant_q     <= last_grant_d;
      response_error_q <= response_error_d;
    end
  end

  assign response_error = response_error_q;

  owner_tag_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_tag_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .push_tag (fifo_push_tag),
    .pop      (fifo_pop),
    .pop_tag  (fifo_pop_tag),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

`ifdef MEMORY_ARBITER_PERF_EN
  logic [31:0] fetch_stall_q, fetch_stall_d;
  logic [31:0] data_stall_q, data_stall_d;

  always_comb begin
    fetch_stall_d = fetch_stall_q;
    data_stall_d  = data_stall_q;
    if (fetch_read && !fetch_grant && (fetch_stall_q != 32'hFFFF_FFFF))
      fetch_stall_d = fetch_stall_q + 32'd1;
    if ((data_read || data_write) && !data_grant && (data_stall_q != 32'hFFFF_FFFF))
      data_stall_d = data_stall_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_stall_q <= '0;
      data_stall_q  <= '0;
    end else begin
      fetch_stall_q <= fetch_stall_d;
      data_stall_q  <= data_stall_d;
    end
  end

  assign fetch_stall_count = fetch_stall_q;
  assign data_stall_count  = data_stall_q;
`endif

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (scan) begin
      $display("core %0d: fetch_grant=%0b data_grant=%0b tags=%0d",
               CORE, fetch_grant, data_grant, fifo_count);
    end
  end
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed and random checks of memory_port_arbiter against a queue-based
// model of round-robin grants and in-order response steering.
module tb_memory_port_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 20;
  localparam int OUT = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_read = 1'b0;
  logic [AW-1:0] fetch_address = '0;
  logic          fetch_grant, fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          data_read = 1'b0, data_write = 1'b0;
  logic [AW-1:0] data_address = '0;
  logic [DW-1:0] data_write_data = '0;
  logic          data_grant, data_valid;
  logic [DW-1:0] data_load_data;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_ready = 1'b0;
  logic          memory_valid = 1'b0;
  logic [DW-1:0] memory_data_in = '0;
  logic          response_error;
  logic          scan = 1'b0;
`ifdef MEMORY_ARBITER_PERF_EN
  logic [31:0]   fetch_stall_count, data_stall_count;
`endif

  memory_port_arbiter #(
    .CORE (0), .DATA_WIDTH (DW), .ADDRESS_BITS (AW), .OUTSTANDING (OUT)
  ) dut (
    .clock (clock), .reset (reset),
    .fetch_read (fetch_read), .fetch_address (fetch_address),
    .fetch_grant (fetch_grant), .fetch_valid (fetch_valid), .fetch_data (fetch_data),
    .data_read (data_read), .data_write (data_write), .data_address (data_address),
    .data_write_data (data_write_data), .data_grant (data_grant),
    .data_valid (data_valid), .data_load_data (data_load_data),
    .mem_read (mem_read), .mem_write (mem_write), .mem_address (mem_address),
    .mem_write_data (mem_write_data), .mem_ready (mem_ready),
    .memory_valid (memory_valid), .memory_data_in (memory_data_in),
    .response_error (response_error),
`ifdef MEMORY_ARBITER_PERF_EN
    .fetch_stall_count (fetch_stall_count), .data_stall_count (data_stall_count),
`endif
    .scan (scan)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of owners of outstanding reads (0 fetch, 1 data),
  // who won the last grant, and the sticky error flag.
  int   exp_q[$];
  logic last_was_data;
  logic err_m;

  logic          g_fg, g_dg, g_mr, g_mw, g_fv, g_dv, g_err;
  logic [DW-1:0] g_fd, g_dd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_was_data = 1'b1;
    err_m = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    fetch_read = 0; data_read = 0; data_write = 0; mem_ready = 0; memory_valid = 0;
    #2;
    chk("rst_fetch_grant", 32'(fetch_grant), 0);
    chk("rst_data_grant", 32'(data_grant), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_fetch_valid", 32'(fetch_valid), 0);
    chk("rst_data_valid", 32'(data_valid), 0);
    chk("rst_response_error", 32'(response_error), 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic fr, input logic [AW-1:0] fa, input logic drd,
                      input logic dwr, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                      input logic rdy, input logic mv, input logic [DW-1:0] md);
    logic full, fe, dre, dwe, fw, dwin, e_mr, e_mw, e_fv, e_dv;
    logic [AW-1:0] e_ma;
    logic [DW-1:0] e_mwd;
    @(negedge clock);
    fetch_read = fr; fetch_address = fa; data_read = drd; data_write = dwr;
    data_address = da; data_write_data = dd; mem_ready = rdy;
    memory_valid = mv; memory_data_in = md;
    #2;
    full = (exp_q.size() == OUT);
    fe   = fr && !full;
    dwe  = dwr;
    dre  = drd && !dwr && !full;
    fw   = 1'b0;
    dwin = 1'b0;
    if (rdy) begin
      if (fe && (dwe || dre)) begin
        fw   = last_was_data;
        dwin = !last_was_data;
      end else begin
        fw   = fe;
        dwin = dwe || dre;
      end
    end
    e_mr  = fw || (dwin && dre);
    e_mw  = dwin && dwe;
    e_ma  = fw ? fa : (dwin ? da : '0);
    e_mwd = e_mw ? dd : '0;
    e_fv  = mv && (exp_q.size() > 0) && (exp_q[0] == 0);
    e_dv  = mv && (exp_q.size() > 0) && (exp_q[0] == 1);
    chk("fetch_grant", 32'(fetch_grant), 32'(fw));
    chk("data_grant", 32'(data_grant), 32'(dwin));
    chk("mem_read", 32'(mem_read), 32'(e_mr));
    chk("mem_write", 32'(mem_write), 32'(e_mw));
    chk("mem_address", 32'(mem_address), 32'(e_ma));
    chk("mem_write_data", mem_write_data, e_mwd);
    chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
    chk("data_valid", 32'(data_valid), 32'(e_dv));
    chk("fetch_data", fetch_data, e_fv ? md : '0);
    chk("data_load_data", data_load_data, e_dv ? md : '0);
    chk("response_error", 32'(response_error), 32'(err_m));
    g_fg = fetch_grant; g_dg = data_grant; g_mr = mem_read; g_mw = mem_write;
    g_fv = fetch_valid; g_dv = data_valid; g_fd = fetch_data; g_dd = data_load_data;
    g_err = response_error;
    if (mv) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      else err_m = 1'b1;
    end
    if (e_mr) exp_q.push_back(fw ? 0 : 1);
    if (fw) last_was_data = 1'b0;
    if (dwin) last_was_data = 1'b1;
  endtask

  task automatic idle();
    step(0, '0, 0, 0, '0, '0, 1, 0, '0);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Single fetch read, response two cycles later
    step(1, 20'h100, 0, 0, '0, '0, 1, 0, '0);
    chk("fo_grant", 32'(g_fg), 1);
    chk("fo_mem_read", 32'(g_mr), 1);
    idle();
    step(0, '0, 0, 0, '0, '0, 1, 1, 32'hDEADBEEF);
    chk("fo_valid", 32'(g_fv), 1);
    chk("fo_data", g_fd, 32'hDEADBEEF);
    chk("fo_dvalid", 32'(g_dv), 0);

    // Contest: both read for four cycles, grants alternate starting with fetch
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, AW'(20'h200 + i), 1, 0, AW'(20'h300 + i), '0, 1, 0, '0);
      chk($sformatf("ct_fetch_grant%0d", i), 32'(g_fg), 32'(i % 2 == 0));
      chk($sformatf("ct_data_grant%0d", i), 32'(g_dg), 32'(i % 2 == 1));
    end
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 0, 0, '0, '0, 1, 1, 32'hA0 + 32'(i));
      chk($sformatf("ct_fetch_valid%0d", i), 32'(g_fv), 32'(i % 2 == 0));
      chk($sformatf("ct_data_valid%0d", i), 32'(g_dv), 32'(i % 2 == 1));
    end

    // Full: reads blocked, write still granted, pop does not free a same-cycle push
    do_reset();
    for (int i = 0; i < OUT; i++) step(1, AW'(20'h400 + i), 0, 0, '0, '0, 1, 0, '0);
    step(1, 20'h404, 0, 1, 20'h500, 32'h12345678, 1, 0, '0);
    chk("full_fetch_grant", 32'(g_fg), 0);
    chk("full_data_grant", 32'(g_dg), 1);
    chk("full_mem_write", 32'(g_mw), 1);
    step(1, 20'h404, 0, 0, '0, '0, 1, 1, 32'h11);
    chk("full_pop_no_push", 32'(g_fg), 0);
    chk("full_pop_valid", 32'(g_fv), 1);
    step(1, 20'h404, 0, 0, '0, '0, 1, 0, '0);
    chk("full_after_pop", 32'(g_fg), 1);
    for (int i = 0; i < OUT; i++) step(0, '0, 0, 0, '0, '0, 1, 1, 32'h20 + 32'(i));

    // Backpressure
    step(1, 20'h600, 1, 0, 20'h700, '0, 0, 0, '0);
    chk("bp_fetch_grant", 32'(g_fg), 0);
    chk("bp_data_grant", 32'(g_dg), 0);
    chk("bp_mem_read", 32'(g_mr), 0);
    chk("bp_mem_write", 32'(g_mw), 0);

    // Push and pop in the same cycle keeps order
    do_reset();
    step(1, 20'h10, 0, 0, '0, '0, 1, 0, '0);
    step(0, '0, 1, 0, 20'h20, '0, 1, 0, '0);
    step(1, 20'h30, 0, 0, '0, '0, 1, 1, 32'h55);
    chk("pp_grant", 32'(g_fg), 1);
    chk("pp_fvalid", 32'(g_fv), 1);
    chk("pp_fdata", g_fd, 32'h55);
    step(0, '0, 0, 0, '0, '0, 1, 1, 32'h66);
    chk("pp_dvalid", 32'(g_dv), 1);
    chk("pp_ddata", g_dd, 32'h66);
    step(0, '0, 0, 0, '0, '0, 1, 1, 32'h77);
    chk("pp_fvalid2", 32'(g_fv), 1);

    // Reset flushes outstanding tags; late response flags an error
    step(1, 20'h40, 0, 0, '0, '0, 1, 0, '0);
    step(1, 20'h44, 0, 0, '0, '0, 1, 0, '0);
    do_reset();
    step(0, '0, 0, 0, '0, '0, 1, 1, 32'h99);
    chk("flush_fvalid", 32'(g_fv), 0);
    chk("flush_dvalid", 32'(g_dv), 0);
    idle();
    chk("flush_err", 32'(g_err), 1);
    idle();
    chk("flush_err_held", 32'(g_err), 1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic mv;
      mv = (exp_q.size() > 0) ? logic'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0);
      step(logic'($urandom_range(0, 1)), AW'($urandom), logic'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), AW'($urandom), $urandom,
           ($urandom_range(0, 3) != 0), mv, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
